// File: rtl/vend_pkg.sv
//------------------------------------------------------------------------------
// Module   : vend_pkg
// Brief    : Shared state encoding and constants for the vending controller.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCUM    = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_REFUND   = 2'd3
  } vend_state_e;

  localparam int unsigned c_CREDIT_W = 6;
  localparam int unsigned c_HOLD_W   = 26;

  localparam logic [c_CREDIT_W-1:0] c_COIN5  = 6'd5;
  localparam logic [c_CREDIT_W-1:0] c_COIN10 = 6'd10;

endpackage

`default_nettype wire

// File: rtl/vend_hold_timer.sv
//------------------------------------------------------------------------------
// Module   : vend_hold_timer
// Brief    : Loadable down-counter that times the dispense/refund indication.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vend_hold_timer
  import vend_pkg::*;
#(
  parameter int unsigned HOLD_CYC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic zero_o
);

  localparam logic [c_HOLD_W-1:0] c_LOAD_VAL = c_HOLD_W'(HOLD_CYC - 1);
  localparam logic [c_HOLD_W-1:0] c_ONE      = c_HOLD_W'(1);

  logic [c_HOLD_W-1:0] count_q;
  logic [c_HOLD_W-1:0] count_d;

  // Parks at zero once expired so an idle timer never wraps.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = c_LOAD_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - c_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/vend_ctrl.sv
//------------------------------------------------------------------------------
// Module   : vend_ctrl
// Brief    : Coin accumulation, dispense and cancel/refund control FSM.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE    = 25,
  parameter int unsigned HOLD_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       c5_flag,
  input  logic       c5_val,
  input  logic       c10_flag,
  input  logic       c10_val,
  input  logic       cancel_flag,
  input  logic       cancel_val,
  output logic [5:0] credit,
  output logic       dispense,
  output logic [5:0] change,
  output logic       refund,
  output logic       busy
);

  localparam logic [c_CREDIT_W-1:0] c_PRICE = c_CREDIT_W'(PRICE);

  vend_state_e           state_q;
  logic [c_CREDIT_W-1:0] credit_q;
  logic [c_CREDIT_W-1:0] change_q;
  logic                  dispense_q;
  logic                  refund_q;
  logic                  busy_q;

  logic                  w_c5_evt;
  logic                  w_c10_evt;
  logic                  w_cancel_evt;
  logic                  w_coin_evt;
  logic [c_CREDIT_W-1:0] w_coin_val;
  logic [c_CREDIT_W-1:0] w_sum;
  logic                  w_taking;
  logic                  w_go_ref;
  logic                  w_go_disp;
  logic                  w_hold_zero;

  // Keys are active-low levels qualified by the debounce strobe.
  assign w_c5_evt     = c5_flag     & ~c5_val;
  assign w_c10_evt    = c10_flag    & ~c10_val;
  assign w_cancel_evt = cancel_flag & ~cancel_val;

  assign w_coin_evt = w_c10_evt | w_c5_evt;
  assign w_coin_val = w_c10_evt ? c_COIN10 : c_COIN5;
  assign w_sum      = credit_q + w_coin_val;
  assign w_taking   = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
  assign w_go_ref   = w_taking && w_cancel_evt && (state_q == ST_ACCUM);
  assign w_go_disp  = w_taking && !w_cancel_evt && w_coin_evt && (w_sum >= c_PRICE);

  vend_hold_timer #(
    .HOLD_CYC (HOLD_CYC)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (w_go_ref | w_go_disp),
    .zero_o (w_hold_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      change_q   <= '0;
      dispense_q <= 1'b0;
      refund_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          // A cancel always wins, even from IDLE where it is a no-op.
          if (w_go_ref) begin
            state_q  <= ST_REFUND;
            change_q <= credit_q;
            refund_q <= 1'b1;
            busy_q   <= 1'b1;
          end else if (!w_cancel_evt && w_coin_evt) begin
            credit_q <= w_sum;
            if (w_go_disp) begin
              state_q    <= ST_DISPENSE;
              change_q   <= w_sum - c_PRICE;
              dispense_q <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              state_q <= ST_ACCUM;
            end
          end
        end
        default: begin
          if (w_hold_zero) begin
            state_q    <= ST_IDLE;
            credit_q   <= '0;
            change_q   <= '0;
            dispense_q <= 1'b0;
            refund_q   <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign credit   = credit_q;
  assign change   = change_q;
  assign dispense = dispense_q;
  assign refund   = refund_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_vend_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_vend_ctrl
// Brief    : Self-checking bench for vend_ctrl with a pulse scoreboard.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_vend_ctrl;

  localparam int unsigned PRICE    = 25;
  localparam int unsigned HOLD_CYC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       c5_flag, c5_val, c10_flag, c10_val, cancel_flag, cancel_val;
  logic [5:0] credit;
  logic       dispense;
  logic [5:0] change;
  logic       refund;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         is_ref;
    logic [5:0] chg;
    int         len;
  } exp_t;

  exp_t sb_q[$];

  vend_ctrl #(
    .PRICE    (PRICE),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .c5_flag     (c5_flag),
    .c5_val      (c5_val),
    .c10_flag    (c10_flag),
    .c10_val     (c10_val),
    .cancel_flag (cancel_flag),
    .cancel_val  (cancel_val),
    .credit      (credit),
    .dispense    (dispense),
    .change      (change),
    .refund      (refund),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor: measures each dispense/refund pulse and scores it.
  bit         mon_active = 1'b0;
  bit         mon_ref;
  logic [5:0] mon_chg;
  int         mon_len;
  exp_t       mon_exp;

  always @(negedge clk) begin
    if (dispense || refund) begin
      if (!mon_active) begin
        mon_active = 1'b1;
        mon_ref    = refund;
        mon_chg    = change;
        mon_len    = 1;
      end else begin
        mon_len++;
        total++;
        if (change !== mon_chg) begin
          bad++;
          $display("FAIL change_stable got=%0d exp=%0d", change, mon_chg);
        end
      end
    end else if (mon_active) begin
      mon_active = 1'b0;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse got ref=%0d chg=%0d len=%0d exp none", mon_ref, mon_chg, mon_len);
      end else begin
        mon_exp = sb_q.pop_front();
        if (mon_ref !== mon_exp.is_ref || mon_chg !== mon_exp.chg || mon_len != mon_exp.len) begin
          bad++;
          $display("FAIL pulse got ref=%0d chg=%0d len=%0d exp ref=%0d chg=%0d len=%0d",
                   mon_ref, mon_chg, mon_len, mon_exp.is_ref, mon_exp.chg, mon_exp.len);
        end
      end
    end
  end

  task automatic push_exp(input bit is_ref, input logic [5:0] chg, input int len);
    exp_t e;
    e.is_ref = is_ref;
    e.chg    = chg;
    e.len    = len;
    sb_q.push_back(e);
  endtask

  // Drives one strobe cycle starting at a falling edge; returns at the next one.
  task automatic press(input bit k5, input bit k10, input bit kc, input bit v);
    c5_flag     = k5;
    c5_val      = k5  ? v : 1'b1;
    c10_flag    = k10;
    c10_val     = k10 ? v : 1'b1;
    cancel_flag = kc;
    cancel_val  = kc  ? v : 1'b1;
    @(negedge clk);
    c5_flag     = 1'b0;
    c10_flag    = 1'b0;
    cancel_flag = 1'b0;
    c5_val      = 1'b1;
    c10_val     = 1'b1;
    cancel_val  = 1'b1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy && !dispense && !refund) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if ({credit, change, dispense, refund, busy} !== 15'd0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", {credit, change, dispense, refund, busy});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_exact_price();
    bit ok;
    press(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (credit !== 6'd10) begin bad++; $display("FAIL credit_first got=%0d exp=10", credit); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (credit !== 6'd20) begin bad++; $display("FAIL credit_second got=%0d exp=20", credit); end
    push_exp(1'b0, 6'd0, HOLD_CYC);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (dispense !== 1'b1 || busy !== 1'b1 || credit !== 6'd25) begin
      bad++;
      $display("FAIL dispense_rise got disp=%0d busy=%0d credit=%0d exp 1 1 25", dispense, busy, credit);
    end
    wait_idle(ok);
    total++;
    if (!ok || credit !== 6'd0 || change !== 6'd0 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL exact_end got ok=%0d credit=%0d change=%0d pending=%0d exp 1 0 0 0", ok, credit, change, sb_q.size());
    end
  endtask

  task automatic test_change();
    bit ok;
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    push_exp(1'b0, 6'd5, HOLD_CYC);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (change !== 6'd5 || credit !== 6'd30) begin
      bad++;
      $display("FAIL change_value got change=%0d credit=%0d exp 5 30", change, credit);
    end
    wait_idle(ok);
    total++;
    if (!ok || sb_q.size() != 0) begin
      bad++;
      $display("FAIL change_end got ok=%0d pending=%0d exp 1 0", ok, sb_q.size());
    end
  endtask

  task automatic test_refund();
    bit ok;
    press(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    total++;
    if (refund !== 1'b0 || busy !== 1'b0 || credit !== 6'd0) begin
      bad++;
      $display("FAIL idle_cancel got refund=%0d busy=%0d credit=%0d exp 0 0 0", refund, busy, credit);
    end
    press(1'b1, 1'b0, 1'b0, 1'b0);
    push_exp(1'b1, 6'd5, HOLD_CYC);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (refund !== 1'b1 || dispense !== 1'b0 || change !== 6'd5) begin
      bad++;
      $display("FAIL refund_rise got refund=%0d disp=%0d change=%0d exp 1 0 5", refund, dispense, change);
    end
    wait_idle(ok);
    total++;
    if (!ok || credit !== 6'd0 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL refund_end got ok=%0d credit=%0d pending=%0d exp 1 0 0", ok, credit, sb_q.size());
    end
  endtask

  task automatic test_priority();
    bit ok;
    press(1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (credit !== 6'd10) begin bad++; $display("FAIL c5_c10_same got=%0d exp=10", credit); end
    push_exp(1'b1, 6'd10, HOLD_CYC);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle(ok);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    push_exp(1'b1, 6'd5, HOLD_CYC);
    press(1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if (refund !== 1'b1 || change !== 6'd5 || credit !== 6'd5) begin
      bad++;
      $display("FAIL cancel_over_c10 got refund=%0d change=%0d credit=%0d exp 1 5 5", refund, change, credit);
    end
    wait_idle(ok);
    total++;
    if (!ok || sb_q.size() != 0) begin
      bad++;
      $display("FAIL priority_end got ok=%0d pending=%0d exp 1 0", ok, sb_q.size());
    end
  endtask

  task automatic test_ignored();
    bit ok;
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b1);
    total++;
    if (credit !== 6'd10) begin bad++; $display("FAIL release_ignored got=%0d exp=10", credit); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    push_exp(1'b0, 6'd0, HOLD_CYC);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (credit !== 6'd25 || busy !== 1'b1) begin
      bad++;
      $display("FAIL coin_in_dispense got credit=%0d busy=%0d exp 25 1", credit, busy);
    end
    wait_idle(ok);
    total++;
    if (!ok || credit !== 6'd0 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL ignored_end got ok=%0d credit=%0d pending=%0d exp 1 0 0", ok, credit, sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    push_exp(1'b0, 6'd0, 2);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({credit, change, dispense, refund, busy} !== 15'd0) begin
      bad++;
      $display("FAIL reset_mid got=%h exp=0", {credit, change, dispense, refund, busy});
    end
    rst_n = 1'b1;
    @(negedge clk);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (credit !== 6'd5 || busy !== 1'b0) begin
      bad++;
      $display("FAIL after_reset got credit=%0d busy=%0d exp 5 0", credit, busy);
    end
    push_exp(1'b1, 6'd5, HOLD_CYC);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle(ok);
    total++;
    if (!ok || sb_q.size() != 0) begin
      bad++;
      $display("FAIL reset_mid_end got ok=%0d pending=%0d exp 1 0", ok, sb_q.size());
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    c5_flag     = 1'b0;
    c5_val      = 1'b1;
    c10_flag    = 1'b0;
    c10_val     = 1'b1;
    cancel_flag = 1'b0;
    cancel_val  = 1'b1;
    @(negedge clk);
    test_reset();
    test_exact_price();
    test_change();
    test_refund();
    test_priority();
    test_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter PRICE, default 25, item price in 0.1-yuan units; legal range 5..50, multiple of 5.
REQ-002 Parameter HOLD_CYC, default 50_000_000, cycles the dispense/refund indication is held (1 s at 50 MHz); legal range 2..2^26-1.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 c5_flag  input  1  one-cycle strobe from the 0.5-yuan coin key debounce stage.
REQ-006 c5_val  input  1  debounced 0.5-yuan key level, valid when c5_flag=1; 0 = pressed.
REQ-007 c10_flag  input  1  one-cycle strobe from the 1-yuan coin key debounce stage.
REQ-008 c10_val  input  1  debounced 1-yuan key level, valid when c10_flag=1; 0 = pressed.
REQ-009 cancel_flag  input  1  one-cycle strobe from the cancel key debounce stage.
REQ-010 cancel_val  input  1  debounced cancel key level, valid when cancel_flag=1; 0 = pressed.
REQ-011 credit  output  6  accumulated credit, 0.1-yuan units.
REQ-012 dispense  output  1  high for exactly HOLD_CYC cycles when an item is released.
REQ-013 change  output  6  change amount, 0.1-yuan units; valid while dispense or refund is high, 0 otherwise.
REQ-014 refund  output  1  high for exactly HOLD_CYC cycles on a cancel refund.
REQ-015 busy  output  1  high in DISPENSE or REFUND; key events are ignored.

Function
REQ-016 A key event occurs on a cycle with flag=1 and val=0; flag=1 with val=1 (release) is not an event.
REQ-017 Event values: c5 = 5, c10 = 10.
REQ-018 States: IDLE (credit=0), ACCUM (0<credit<PRICE), DISPENSE, REFUND; encoding is a 2-bit enum.
REQ-019 Simultaneous events in one cycle: cancel > c10 > c5; only the highest-priority event is taken and the others are discarded.
REQ-020 IDLE/ACCUM, coin event: credit<=credit+value on the next edge; if the new sum >= PRICE, go to DISPENSE with change=sum-PRICE, otherwise go to ACCUM.
REQ-021 Transition to DISPENSE and the credit update take effect on the same edge; dispense rises one cycle after the event cycle.
REQ-022 ACCUM, cancel event: go to REFUND with change=credit.
REQ-023 IDLE, cancel event: ignored; stay in IDLE with no refund pulse.
REQ-024 Entering DISPENSE/REFUND loads the hold counter with HOLD_CYC-1; it decrements each cycle.
REQ-025 At hold count 0: return to IDLE, clear credit and change, and drop dispense/refund on the next edge.
REQ-026 All events during DISPENSE/REFUND are ignored and not queued.
REQ-027 credit saturation: max reachable sum is PRICE+5 <= 55; 6 bits never wrap.
REQ-028 All outputs are registered; there is no combinational input-to-output path.

Reset
REQ-029 rst_n=0 at an edge forces IDLE, credit=0, change=0, dispense=0, refund=0, busy=0, hold counter=0.
REQ-030 Reset mid-DISPENSE/REFUND aborts the pulse on the next edge; no residual credit is kept.
REQ-031 Inputs are ignored on any cycle where rst_n=0.

Structure
REQ-032 Shared package vend_pkg holds the state enum, coin value constants (5, 10) and the credit width (6).
REQ-033 One sub-module, vend_hold_timer (load/decrement/zero flag, 26 bits), is instantiated once and shared by DISPENSE and REFUND.
REQ-034 The upstream debounce stages connect directly; this block adds no synchronisers.

Verification (HOLD_CYC=4 in bench)
REQ-035 Sequence c10, c10, c5 (PRICE 25) -> credit 10, then 20; dispense high 4 cycles, change=0; then IDLE, credit=0.
REQ-036 Sequence c10, c10, c10 -> dispense high 4 cycles, change=5.
REQ-037 Sequence c5 then cancel -> refund high 4 cycles, change=5, credit cleared, dispense stays 0.
REQ-038 Same-cycle c5 and c10 from IDLE -> credit=10; same-cycle cancel and c10 in ACCUM credit 5 -> refund with change=5.
REQ-039 Coin events during DISPENSE, and flag=1 with val=1 -> no credit change.
REQ-040 rst_n=0 during the 2nd DISPENSE cycle -> all outputs 0 next edge; after release, c5 yields credit=5.
